j1_io_bridge: RTL

//  Parametrised I/O interconnect between the J1 CPU I/O port and NUM_SLAVES memory-mapped peripherals.

---
 rtl/j1_io_bridge_pkg.sv | 19 +
 rtl/j1_io_bridge_decoder.sv | 31 +++
 rtl/j1_io_bridge.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/j1_io_bridge_pkg.sv
// Shared definitions for the J1 I/O bridge: FSM states, status bits
// and the default j1soc page map.
package j1_io_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    localparam int STAT_TO  = 0;
    localparam int STAT_UM  = 1;
    localparam int STAT_CNT = 4;
    localparam int STAT_PG  = 8;

    localparam logic [39:0] J1_PAGE_MAP = {8'h71, 8'h70, 8'h69, 8'h68, 8'h67};

endpackage

// File: rtl/j1_io_bridge_decoder.sv
// Page decoder: page -> one-hot slave select plus hit/status-hit flags.
// The status page shadows any slave mapped to the same page.
module j1_io_bridge_decoder
    import j1_io_bridge_pkg::*;
#(
    parameter int                           NUM_SLAVES = 5,
    parameter int                           PAGE_W     = 8,
    parameter logic [NUM_SLAVES*PAGE_W-1:0] PAGE_MAP   = J1_PAGE_MAP,
    parameter logic [PAGE_W-1:0]            STAT_PAGE  = 8'hFF
) (
    input  logic [PAGE_W-1:0]     page,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  hit,
    output logic                  stat_hit
);

    always_comb begin
        sel      = '0;
        hit      = 1'b0;
        stat_hit = (page == STAT_PAGE);
        // Descending scan so the lowest matching index is written last.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (!stat_hit && page == PAGE_MAP[i*PAGE_W +: PAGE_W]) begin
                sel    = '0;
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/j1_io_bridge.sv
// J1 CPU I/O bridge: page-decoded access FSM with ack handshake,
// per-access timeout and a sticky bus-error status register.
module j1_io_bridge
    import j1_io_bridge_pkg::*;
#(
    parameter int                           NUM_SLAVES   = 5,
    parameter int                           DATA_W       = 16,
    parameter int                           ADDR_W       = 16,
    parameter int                           PAGE_W       = 8,
    parameter logic [NUM_SLAVES*PAGE_W-1:0] PAGE_MAP     = J1_PAGE_MAP,
    parameter int                           TIMEOUT      = 15,
    parameter logic [DATA_W-1:0]            DEFAULT_DATA = 16'h0666,
    parameter logic [PAGE_W-1:0]            STAT_PAGE    = 8'hFF
) (
    input  logic                         sys_clk_i,
    input  logic                         sys_rst_i,
    input  logic                         cpu_rd_i,
    input  logic                         cpu_wr_i,
    input  logic [ADDR_W-1:0]            cpu_addr_i,
    input  logic [DATA_W-1:0]            cpu_dout_i,
    output logic [DATA_W-1:0]            cpu_din_o,
    output logic                         cpu_ready_o,
    output logic [NUM_SLAVES-1:0]        per_cs_o,
    output logic                         per_rd_o,
    output logic                         per_wr_o,
    output logic [ADDR_W-1:0]            per_addr_o,
    output logic [DATA_W-1:0]            per_dout_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] per_din_i,
    input  logic [NUM_SLAVES-1:0]        per_ack_i,
    output logic                         err_irq_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t                state, state_nx;
    logic [NUM_SLAVES-1:0] dec_sel, sel_q;
    logic                  dec_hit, dec_stat;
    logic                  wr_q, req, both, ack;
    logic                  err_to, err_um, clr;
    logic [CNT_W-1:0]      cnt;
    logic [15:0]           stat_q;
    logic [PAGE_W-1:0]     page, err_page;
    logic [DATA_W-1:0]     rd_mux, stat_word;

    assign page      = cpu_addr_i[ADDR_W-1 -: PAGE_W];
    // The ready cycle blocks re-acceptance of the still-held request.
    assign req       = (cpu_rd_i | cpu_wr_i) & ~cpu_ready_o;
    assign both      = cpu_rd_i & cpu_wr_i;
    assign ack       = |(per_ack_i & sel_q);
    assign stat_word = DATA_W'(stat_q);
    assign err_page  = err_to ? per_addr_o[ADDR_W-1 -: PAGE_W] : page;
    assign err_irq_o = |stat_q[1:0];

    assign per_cs_o = (state == ACCESS || state == WAIT) ? sel_q : '0;
    assign per_rd_o = (state == ACCESS) & ~wr_q;
    assign per_wr_o = (state == ACCESS) & wr_q;

    j1_io_bridge_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .PAGE_W     (PAGE_W),
        .PAGE_MAP   (PAGE_MAP),
        .STAT_PAGE  (STAT_PAGE)
    ) u_dec (
        .page     (page),
        .sel      (dec_sel),
        .hit      (dec_hit),
        .stat_hit (dec_stat)
    );

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) rd_mux = rd_mux | per_din_i[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_nx = state;
        err_um   = 1'b0;
        err_to   = 1'b0;
        clr      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (both || (!dec_hit && !dec_stat)) begin
                        state_nx = RESP;
                        err_um   = 1'b1;
                    end else if (dec_stat) begin
                        state_nx = RESP;
                        clr      = cpu_wr_i & cpu_dout_i[0];
                    end else begin
                        state_nx = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (ack) begin
                    state_nx = RESP;
                end else if (TIMEOUT == 1) begin
                    state_nx = RESP;
                    err_to   = 1'b1;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                // ACCESS is the first wait cycle, so WAIT expires one early.
                if (ack) begin
                    state_nx = RESP;
                end else if (int'(cnt) == TIMEOUT - 2) begin
                    state_nx = RESP;
                    err_to   = 1'b1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state       <= IDLE;
            sel_q       <= '0;
            wr_q        <= 1'b0;
            cnt         <= '0;
            per_addr_o  <= '0;
            per_dout_o  <= '0;
            cpu_din_o   <= DEFAULT_DATA;
            cpu_ready_o <= 1'b0;
        end else begin
            state       <= state_nx;
            cpu_ready_o <= (state == RESP);
            if (state == IDLE && req) begin
                per_addr_o <= cpu_addr_i;
                per_dout_o <= cpu_dout_i;
                wr_q       <= cpu_wr_i & ~cpu_rd_i;
                sel_q      <= both ? '0 : dec_sel;
                if (dec_stat && !both && cpu_rd_i) cpu_din_o <= stat_word;
            end
            if (state == ACCESS) cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 1'b1;
            if ((state == ACCESS || state == WAIT) && ack && !wr_q)
                cpu_din_o <= rd_mux;
            if (err_um || err_to) cpu_din_o <= DEFAULT_DATA;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            stat_q <= '0;
        end else if (err_um || err_to) begin
            stat_q[STAT_TO] <= stat_q[STAT_TO] | err_to;
            stat_q[STAT_UM] <= stat_q[STAT_UM] | err_um;
            if (stat_q[STAT_CNT +: 4] != 4'hF)
                stat_q[STAT_CNT +: 4] <= stat_q[STAT_CNT +: 4] + 4'd1;
            stat_q[STAT_PG +: 8] <= 8'(err_page);
        end else if (clr) begin
            stat_q <= '0;
        end
    end

endmodule
